// File: rtl/a2_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// a2_hazard_scoreboard
//
// Register-write scoreboard and issue controller for the 8-bit pipelined
// datapath. Each architectural register has a small counter of issued writes
// that have not yet come back from write-back. An instruction at issue (ID) is
// held while one of the sources it reads still has a write in flight, or while
// its destination counter is already at its maximum value. The block also
// provides a pipeline-wide flush of all counters and a saturating count of
// stall cycles.
//
// Optional feature (compile-time macro):
//   A2_WB_BYPASS_EN  - a source whose last in-flight producer is writing back
//                      in the current cycle is not treated as busy. The
//                      register file writes before it reads, so the consumer
//                      may issue in that same cycle. The destination
//                      saturation check does not use this.
//
// Parameters:
//   NREG          number of architectural registers (3-bit addresses)
//   CNT_W         width of each per-register in-flight counter
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         synchronous active-low reset
//   id_valid      instruction present at issue
//   id_rs         first source register
//   id_rs_used    id_rs is read
//   id_rt         second source register
//   id_rt_used    id_rt is read
//   id_WriteReg   instruction writes a register
//   id_rd         destination register
//   id_ready      issue permitted this cycle (combinational)
//   stall         id_valid & ~id_ready (combinational)
//   wb_WriteReg   write-back stage performs a register write
//   wb_rd         write-back destination register
//   flush         squash every in-flight write
//   pending       bit r set when register r has writes in flight (registered)
//   stall_cnt     saturating count of stall cycles (registered)
//   err_underflow sticky: write-back seen for a register with no write in flight
// -----------------------------------------------------------------------------
module a2_hazard_scoreboard #(
    parameter int NREG  = 8,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [2:0]      id_rs,
    input  logic            id_rs_used,
    input  logic [2:0]      id_rt,
    input  logic            id_rt_used,
    input  logic            id_WriteReg,
    input  logic [2:0]      id_rd,
    output logic            id_ready,
    output logic            stall,
    input  logic            wb_WriteReg,
    input  logic [2:0]      wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] pending,
    output logic [7:0]      stall_cnt,
    output logic            err_underflow
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [7:0]       SC_MAX   = 8'hFF;

    // Architectural state
    logic [NREG-1:0][CNT_W-1:0] r_cnt;
    logic [NREG-1:0]            r_pending;
    logic [7:0]                 r_stall_cnt;
    logic                       r_err;

    // Counter values selected by the current ID / WB addresses
    logic [CNT_W-1:0] w_cnt_rs;
    logic [CNT_W-1:0] w_cnt_rt;
    logic [CNT_W-1:0] w_cnt_rd;
    logic [CNT_W-1:0] w_cnt_wb;

    // Hazard evaluation
    logic w_byp_rs;
    logic w_byp_rt;
    logic w_busy_rs;
    logic w_busy_rt;
    logic w_dst_full;
    logic w_hazard;
    logic w_ready;
    logic w_accept;

    // Write-back classification
    logic w_wb_hit;
    logic w_wb_underflow;

    // Next-state
    logic [NREG-1:0]            w_inc;
    logic [NREG-1:0]            w_dec;
    logic [NREG-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [NREG-1:0]            w_pend_nxt;

    // Select one register's counter by address. Addresses beyond NREG read as
    // zero instead of indexing outside the array.
    function automatic logic [CNT_W-1:0] f_cnt_at(
        input logic [NREG-1:0][CNT_W-1:0] cnts,
        input logic [2:0]                 idx
    );
        logic [CNT_W-1:0] v;
        v = CNT_ZERO;
        for (int r = 0; r < NREG; r++) begin
            v = (idx == 3'(r)) ? cnts[r] : v;
        end
        return v;
    endfunction

    // Apply one increment and/or one decrement to a counter; both together
    // cancel out.
    function automatic logic [CNT_W-1:0] f_cnt_step(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] v;
        case ({inc, dec})
            2'b10:   v = cnt + CNT_ONE;
            2'b01:   v = cnt - CNT_ONE;
            default: v = cnt;
        endcase
        return v;
    endfunction

    // Look up the counters addressed by the issue and write-back stages
    always_comb begin
        w_cnt_rs = f_cnt_at(r_cnt, id_rs);
        w_cnt_rt = f_cnt_at(r_cnt, id_rt);
        w_cnt_rd = f_cnt_at(r_cnt, id_rd);
        w_cnt_wb = f_cnt_at(r_cnt, wb_rd);
    end

`ifdef A2_WB_BYPASS_EN
    // A source is released when its only outstanding write is retiring now
    assign w_byp_rs = wb_WriteReg & (wb_rd == id_rs) & (w_cnt_rs == CNT_ONE);
    assign w_byp_rt = wb_WriteReg & (wb_rd == id_rt) & (w_cnt_rt == CNT_ONE);
`else
    assign w_byp_rs = 1'b0;
    assign w_byp_rt = 1'b0;
`endif

    // Issue decision from the pre-update counters and the current inputs.
    // The saturation check deliberately ignores a same-cycle write-back.
    always_comb begin
        w_busy_rs  = (w_cnt_rs != CNT_ZERO) & ~w_byp_rs;
        w_busy_rt  = (w_cnt_rt != CNT_ZERO) & ~w_byp_rt;
        w_dst_full = id_WriteReg & (w_cnt_rd == CNT_MAX);
        w_hazard   = (id_rs_used & w_busy_rs) | (id_rt_used & w_busy_rt) | w_dst_full;
        w_ready    = rst_n & ~flush & ~w_hazard;
        w_accept   = id_valid & w_ready;
    end

    assign id_ready = w_ready;
    assign stall    = id_valid & ~w_ready;

    // Classify the write-back: a retiring write, or one with nothing in flight
    always_comb begin
        w_wb_hit       = wb_WriteReg & (w_cnt_wb != CNT_ZERO);
        w_wb_underflow = wb_WriteReg & (w_cnt_wb == CNT_ZERO);
    end

    // Per-register increment/decrement requests
    always_comb begin
        w_inc = {NREG{1'b0}};
        w_dec = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            w_inc[r] = w_accept & id_WriteReg & (id_rd == 3'(r));
            w_dec[r] = w_wb_hit & (wb_rd == 3'(r));
        end
    end

    // Next counter values; flush clears everything and drops any write-back
    always_comb begin
        w_cnt_nxt  = {(NREG*CNT_W){1'b0}};
        w_pend_nxt = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            if (flush) begin
                w_cnt_nxt[r] = CNT_ZERO;
            end else begin
                w_cnt_nxt[r] = f_cnt_step(r_cnt[r], w_inc[r], w_dec[r]);
            end
            w_pend_nxt[r] = (w_cnt_nxt[r] != CNT_ZERO);
        end
    end

    // State update: reset first, then counters, statistics and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= {(NREG*CNT_W){1'b0}};
            r_pending   <= {NREG{1'b0}};
            r_stall_cnt <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pend_nxt;
            if (stall && (r_stall_cnt != SC_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_wb_underflow) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign pending       = r_pending;
    assign stall_cnt     = r_stall_cnt;
    assign err_underflow = r_err;

endmodule
